// File: rtl/fetch_decode_fifo_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_fifo_if
// Bus bundle between the fetch stage, the decode stage and fetch_decode_fifo.
//   data_in        : FETCH_WIDTH packs offered by fetch (slot i at i*DATA_WIDTH)
//   data_in_valid  : per-slot push request from fetch
//   push           : push strobe; no slot is written unless it is high
//   data_in_enable : per-slot free-space advertisement back to fetch
//   data_out       : DECODE_WIDTH oldest packs (slot j = entry rptr+j)
//   data_out_valid : per-slot valid for data_out
//   pop_valid      : per-slot pop from decode (contiguous prefix from bit 0)
//   flush          : discard all contents at the next edge
//   count/full/empty : occupancy status
// Modports: master = fetch/decode/commit side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface fetch_decode_fifo_if #(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DATA_WIDTH   = 128
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH*FETCH_WIDTH-1:0]  data_in;
  logic [FETCH_WIDTH-1:0]             data_in_valid;
  logic                               push;
  logic [FETCH_WIDTH-1:0]             data_in_enable;
  logic [DATA_WIDTH*DECODE_WIDTH-1:0] data_out;
  logic [DECODE_WIDTH-1:0]            data_out_valid;
  logic [DECODE_WIDTH-1:0]            pop_valid;
  logic                               flush;
  logic [CNT_W-1:0]                   count;
  logic                               full;
  logic                               empty;

  modport master (
    output data_in, data_in_valid, push, pop_valid, flush,
    input  data_in_enable, data_out, data_out_valid, count, full, empty
  );

  modport slave (
    input  data_in, data_in_valid, push, pop_valid, flush,
    output data_in_enable, data_out, data_out_valid, count, full, empty
  );
endinterface

// File: rtl/fetch_decode_fifo.sv
// ---------------------------------------------------------------------------
// fetch_decode_fifo
// Multi-port circular FIFO between fetch (producer) and decode (consumer).
// Accepts up to FETCH_WIDTH packs per cycle (valid slots compacted into
// consecutive entries), presents the DECODE_WIDTH oldest packs, and supports
// a single-cycle flush. Status outputs depend only on the registered count,
// so there is no combinational path from push/pop/flush to any status.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (beats flush, same end state)
//   bus  : fetch_decode_fifo_if.slave (see interface header)
// ---------------------------------------------------------------------------
module fetch_decode_fifo #(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DATA_WIDTH   = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_decode_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0]              r_mem [DEPTH];
  logic [PTR_W-1:0]                   r_wptr;
  logic [PTR_W-1:0]                   r_rptr;
  logic [CNT_W-1:0]                   r_count;

  logic [CNT_W-1:0]                   w_free;
  logic [FETCH_WIDTH-1:0]             w_in_enable;
  logic [FETCH_WIDTH-1:0]             w_accept;
  logic [PTR_W-1:0]                   w_waddr [FETCH_WIDTH];
  logic [CNT_W-1:0]                   w_push_cnt;
  logic [CNT_W-1:0]                   w_pop_cnt;
  logic [DECODE_WIDTH-1:0]            w_out_valid;
  logic [DATA_WIDTH*DECODE_WIDTH-1:0] w_data_out;

  // Free space is taken from the registered count, so a same-cycle pop
  // never makes room for a same-cycle push.
  assign w_free = CNT_W'(DEPTH) - r_count;

  // Per-slot enable/valid thermometer codes derived from the count.
  always_comb begin
    w_in_enable = {FETCH_WIDTH{1'b0}};
    w_out_valid = {DECODE_WIDTH{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_in_enable[i] = (w_free > CNT_W'(i));
    end
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      w_out_valid[j] = (r_count > CNT_W'(j));
    end
  end

  // Push compaction: each accepted slot lands at wptr + (number of accepted
  // lower-index slots), so sparse valid patterns fill consecutive entries.
  always_comb begin
    w_push_cnt = {CNT_W{1'b0}};
    w_accept   = {FETCH_WIDTH{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_accept[i] = bus.push & ~bus.flush & bus.data_in_valid[i] & w_in_enable[i];
      w_waddr[i]  = r_wptr + w_push_cnt[PTR_W-1:0];
      if (w_accept[i]) begin
        w_push_cnt = w_push_cnt + CNT_W'(1);
      end else begin
        w_push_cnt = w_push_cnt;
      end
    end
  end

  // Effective pop count; popcount is used even for an illegal non-prefix mask.
  always_comb begin
    w_pop_cnt = {CNT_W{1'b0}};
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (!bus.flush && bus.pop_valid[j] && w_out_valid[j]) begin
        w_pop_cnt = w_pop_cnt + CNT_W'(1);
      end else begin
        w_pop_cnt = w_pop_cnt;
      end
    end
  end

  // Read window: slot j shows the entry at rptr+j, wrapping modulo DEPTH.
  always_comb begin
    w_data_out = {(DATA_WIDTH*DECODE_WIDTH){1'b0}};
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      w_data_out[DATA_WIDTH*j +: DATA_WIDTH] = r_mem[r_rptr + PTR_W'(j)];
    end
  end

  // Pointer and occupancy update; reset first, then flush, then normal traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_wptr  <= r_wptr + w_push_cnt[PTR_W-1:0];
      r_rptr  <= r_rptr + w_pop_cnt[PTR_W-1:0];
      r_count <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

  // Entry storage, deliberately not reset; writes target distinct entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!rst && w_accept[i]) begin
        r_mem[w_waddr[i]] <= bus.data_in[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign bus.data_in_enable = w_in_enable;
  assign bus.data_out_valid = w_out_valid;
  assign bus.data_out       = w_data_out;
  assign bus.count          = r_count;
  assign bus.full           = (r_count == CNT_W'(DEPTH));
  assign bus.empty          = (r_count == {CNT_W{1'b0}});
endmodule

// File: tb/tb_fetch_decode_fifo.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_fifo
// Self-checking bench for fetch_decode_fifo. A queue-based reference model
// tracks the FIFO contents; directed scenarios cover the listed cases and a
// randomized phase compares every status output and valid data slot per cycle.
// ---------------------------------------------------------------------------
module tb_fetch_decode_fifo;
  localparam int DEPTH = 16;
  localparam int FW    = 4;
  localparam int DW    = 4;
  localparam int DWID  = 128;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Reference model: oldest entry at mq[0]; mw/mr track expected pointers.
  logic [DWID-1:0] mq [$];
  int              mw;
  int              mr;

  fetch_decode_fifo_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DATA_WIDTH(DWID)) bus ();

  fetch_decode_fifo #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DATA_WIDTH(DWID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode must only pop a contiguous prefix.
  always @(negedge clk) begin
    if (!rst) begin
      pv_prefix: assert (((bus.pop_valid + 4'd1) & bus.pop_valid) == 4'd0)
        else $error("illegal non-prefix pop_valid %b", bus.pop_valid);
    end
  end

  function automatic logic [DWID-1:0] rnd_pack();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [FW-1:0] exp_die();
    logic [FW-1:0] r;
    for (int i = 0; i < FW; i++) r[i] = ((DEPTH - mq.size()) > i);
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_dov();
    logic [DW-1:0] r;
    for (int j = 0; j < DW; j++) r[j] = (mq.size() > j);
    return r;
  endfunction

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic step(input logic p, input logic [FW-1:0] v, input logic [DWID*FW-1:0] d,
                      input logic [DW-1:0] pv, input logic fl);
    int sz;
    int npop;
    logic [DWID-1:0] acc [$];
    bus.push = p; bus.data_in_valid = v; bus.data_in = d; bus.pop_valid = pv; bus.flush = fl;
    sz = mq.size();
    npop = 0;
    for (int i = 0; i < FW; i++)
      if (p && !fl && v[i] && i < (DEPTH - sz)) acc.push_back(d[DWID*i +: DWID]);
    for (int j = 0; j < DW; j++)
      if (!fl && pv[j] && j < sz) npop++;
    @(posedge clk);
    if (fl) begin
      mq.delete(); mw = 0; mr = 0;
    end else begin
      repeat (npop) void'(mq.pop_front());
      foreach (acc[k]) mq.push_back(acc[k]);
      mw = (mw + acc.size()) % DEPTH;
      mr = (mr + npop) % DEPTH;
    end
    #1;
    bus.push = 1'b0; bus.data_in_valid = '0; bus.pop_valid = '0; bus.flush = 1'b0;
  endtask

  task automatic push4(input logic [FW-1:0] v, output logic [DWID-1:0] pk [FW]);
    logic [DWID*FW-1:0] d;
    for (int i = 0; i < FW; i++) begin pk[i] = rnd_pack(); d[DWID*i +: DWID] = pk[i]; end
    step(1'b1, v, d, 4'b0000, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 4'b0000, '0, 4'b0000, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); mw = 0; mr = 0;
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_checks++; if (bus.data_out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_dov: got %b want 0000", bus.data_out_valid); end
    n_checks++; if (bus.data_in_enable !== 4'b1111) begin n_fail++; $display("FAIL reset_die: got %b want 1111", bus.data_in_enable); end
    rst = 1'b0;
  endtask

  task automatic test_basic_push();
    logic [DWID-1:0] pk [FW];
    push4(4'b1111, pk);
    n_checks++; if (bus.count !== 5'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", bus.count); end
    n_checks++; if (bus.data_out_valid !== 4'b1111) begin n_fail++; $display("FAIL basic_dov: got %b want 1111", bus.data_out_valid); end
    n_checks++; if (bus.data_in_enable !== 4'b1111) begin n_fail++; $display("FAIL basic_die: got %b want 1111", bus.data_in_enable); end
    for (int j = 0; j < DW; j++) begin
      n_checks++;
      if (bus.data_out[DWID*j +: DWID] !== pk[j]) begin
        n_fail++; $display("FAIL basic_slot%0d: got %h want %h", j, bus.data_out[DWID*j +: DWID], pk[j]);
      end
    end
  endtask

  task automatic test_sparse();
    logic [DWID-1:0] pk [FW];
    do_flush();
    push4(4'b1010, pk);
    n_checks++; if (bus.count !== 5'd2) begin n_fail++; $display("FAIL sparse_count: got %0d want 2", bus.count); end
    n_checks++; if (bus.data_out_valid !== 4'b0011) begin n_fail++; $display("FAIL sparse_dov: got %b want 0011", bus.data_out_valid); end
    n_checks++; if (bus.data_out[0 +: DWID] !== pk[1]) begin n_fail++; $display("FAIL sparse_slot0: got %h want %h", bus.data_out[0 +: DWID], pk[1]); end
    n_checks++; if (bus.data_out[DWID +: DWID] !== pk[3]) begin n_fail++; $display("FAIL sparse_slot1: got %h want %h", bus.data_out[DWID +: DWID], pk[3]); end
  endtask

  task automatic test_full();
    logic [DWID-1:0] pk [FW];
    do_flush();
    repeat (3) push4(4'b1111, pk);
    push4(4'b0011, pk);
    n_checks++; if (bus.count !== 5'd14) begin n_fail++; $display("FAIL full_fill14: got %0d want 14", bus.count); end
    n_checks++; if (bus.data_in_enable !== 4'b0011) begin n_fail++; $display("FAIL full_die14: got %b want 0011", bus.data_in_enable); end
    push4(4'b1111, pk);
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", bus.count); end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", bus.full); end
    n_checks++; if (bus.data_in_enable !== 4'b0000) begin n_fail++; $display("FAIL full_die: got %b want 0000", bus.data_in_enable); end
    n_checks++; if (dut.r_mem[14] !== pk[0]) begin n_fail++; $display("FAIL full_mem14: got %h want %h", dut.r_mem[14], pk[0]); end
    n_checks++; if (dut.r_mem[15] !== pk[1]) begin n_fail++; $display("FAIL full_mem15: got %h want %h", dut.r_mem[15], pk[1]); end
    push4(4'b1111, pk);
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_drop: got %0d want 16", bus.count); end
    step(1'b1, 4'b1111, {4{rnd_pack()}}, 4'b0011, 1'b0);
    n_checks++; if (bus.count !== 5'd14) begin n_fail++; $display("FAIL full_pop: got %0d want 14", bus.count); end
    n_checks++; if (bus.data_out[0 +: DWID] !== mq[0]) begin n_fail++; $display("FAIL full_pop_slot0: got %h want %h", bus.data_out[0 +: DWID], mq[0]); end
  endtask

  task automatic test_wrap();
    logic [DWID-1:0] pk [FW];
    logic [DWID-1:0] w [FW];
    do_flush();
    repeat (3) push4(4'b1111, pk);
    push4(4'b0011, pk);
    repeat (3) step(1'b0, 4'b0000, '0, 4'b1111, 1'b0);
    step(1'b0, 4'b0000, '0, 4'b0011, 1'b0);
    n_checks++; if (dut.r_rptr !== 4'd14 || dut.r_wptr !== 4'd14 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_setup: got rptr=%0d wptr=%0d empty=%b want 14 14 1", dut.r_rptr, dut.r_wptr, bus.empty);
    end
    push4(4'b1111, w);
    n_checks++; if (dut.r_mem[14] !== w[0]) begin n_fail++; $display("FAIL wrap_mem14: got %h want %h", dut.r_mem[14], w[0]); end
    n_checks++; if (dut.r_mem[15] !== w[1]) begin n_fail++; $display("FAIL wrap_mem15: got %h want %h", dut.r_mem[15], w[1]); end
    n_checks++; if (dut.r_mem[0] !== w[2]) begin n_fail++; $display("FAIL wrap_mem0: got %h want %h", dut.r_mem[0], w[2]); end
    n_checks++; if (dut.r_mem[1] !== w[3]) begin n_fail++; $display("FAIL wrap_mem1: got %h want %h", dut.r_mem[1], w[3]); end
    for (int j = 0; j < DW; j++) begin
      n_checks++;
      if (bus.data_out[DWID*j +: DWID] !== w[j]) begin
        n_fail++; $display("FAIL wrap_slot%0d: got %h want %h", j, bus.data_out[DWID*j +: DWID], w[j]);
      end
    end
    step(1'b0, 4'b0000, '0, 4'b1111, 1'b0);
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    n_checks++; if (dut.r_rptr !== 4'd2) begin n_fail++; $display("FAIL wrap_rptr: got %0d want 2", dut.r_rptr); end
  endtask

  task automatic test_simultaneous();
    logic [DWID-1:0] a [FW];
    logic [DWID-1:0] b [FW];
    do_flush();
    push4(4'b1111, a);
    push4(4'b0011, b);
    n_checks++; if (bus.count !== 5'd6) begin n_fail++; $display("FAIL simul_setup: got %0d want 6", bus.count); end
    step(1'b1, 4'b0111, {4{rnd_pack()}}, 4'b0011, 1'b0);
    n_checks++; if (bus.count !== 5'd7) begin n_fail++; $display("FAIL simul_count: got %0d want 7", bus.count); end
    n_checks++; if (bus.data_out[0 +: DWID] !== a[2]) begin n_fail++; $display("FAIL simul_slot0: got %h want %h", bus.data_out[0 +: DWID], a[2]); end
    n_checks++; if (bus.data_out[3*DWID +: DWID] !== b[1]) begin n_fail++; $display("FAIL simul_slot3: got %h want %h", bus.data_out[3*DWID +: DWID], b[1]); end
  endtask

  task automatic test_flush();
    logic [DWID-1:0] pk [FW];
    logic [DWID-1:0] f [FW];
    logic [DWID*FW-1:0] d;
    do_flush();
    push4(4'b1111, pk);
    push4(4'b1111, pk);
    push4(4'b0001, pk);
    for (int i = 0; i < FW; i++) begin f[i] = rnd_pack(); d[DWID*i +: DWID] = f[i]; end
    bus.push = 1'b1; bus.data_in_valid = 4'b1111; bus.data_in = d; bus.pop_valid = 4'b1111; bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.count !== 5'd9 || bus.data_out_valid !== 4'b1111) begin
      n_fail++; $display("FAIL flush_prestate: got count=%0d dov=%b want 9 1111", bus.count, bus.data_out_valid);
    end
    @(posedge clk);
    mq.delete(); mw = 0; mr = 0;
    #1;
    bus.push = 1'b0; bus.data_in_valid = '0; bus.pop_valid = '0; bus.flush = 1'b0;
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", bus.empty); end
    n_checks++; if (dut.r_wptr !== 4'd0 || dut.r_rptr !== 4'd0) begin
      n_fail++; $display("FAIL flush_ptrs: got wptr=%0d rptr=%0d want 0 0", dut.r_wptr, dut.r_rptr);
    end
    for (int i = 0; i < FW; i++) begin
      n_checks++;
      if (dut.r_mem[9 + i] === f[i]) begin
        n_fail++; $display("FAIL flush_nostore%0d: got %h want any other value", i, dut.r_mem[9 + i]);
      end
    end
    push4(4'b0001, pk);
    n_checks++; if (bus.count !== 5'd1 || bus.data_out[0 +: DWID] !== pk[0]) begin
      n_fail++; $display("FAIL flush_repush: got count=%0d slot0=%h want 1 %h", bus.count, bus.data_out[0 +: DWID], pk[0]);
    end
  endtask

  task automatic test_rst_flush();
    logic [DWID-1:0] pk [FW];
    push4(4'b1111, pk);
    rst = 1'b1; bus.flush = 1'b1; bus.push = 1'b1; bus.data_in_valid = 4'b1111;
    @(posedge clk);
    mq.delete(); mw = 0; mr = 0;
    #1;
    rst = 1'b0; bus.flush = 1'b0; bus.push = 1'b0; bus.data_in_valid = '0;
    n_checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || dut.r_wptr !== 4'd0) begin
      n_fail++; $display("FAIL rst_flush: got count=%0d empty=%b wptr=%0d want 0 1 0", bus.count, bus.empty, dut.r_wptr);
    end
  endtask

  task automatic test_random();
    logic [DWID*FW-1:0] d;
    logic [DW-1:0] pv;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < FW; i++) d[DWID*i +: DWID] = rnd_pack();
      pv = 4'((1 << $urandom_range(0, 4)) - 1);
      step(($urandom % 4) != 0, 4'($urandom), d, pv, ($urandom % 40) == 0);
      n_checks++; if (bus.count !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, mq.size()); end
      n_checks++; if (bus.data_in_enable !== exp_die()) begin n_fail++; $display("FAIL rnd_die c%0d: got %b want %b", c, bus.data_in_enable, exp_die()); end
      n_checks++; if (bus.data_out_valid !== exp_dov()) begin n_fail++; $display("FAIL rnd_dov c%0d: got %b want %b", c, bus.data_out_valid, exp_dov()); end
      n_checks++; if (bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin
        n_fail++; $display("FAIL rnd_flags c%0d: got full=%b empty=%b want size %0d", c, bus.full, bus.empty, mq.size());
      end
      n_checks++; if (dut.r_wptr !== 4'(mw) || dut.r_rptr !== 4'(mr)) begin
        n_fail++; $display("FAIL rnd_ptrs c%0d: got w=%0d r=%0d want %0d %0d", c, dut.r_wptr, dut.r_rptr, mw, mr);
      end
      for (int j = 0; j < DW; j++) begin
        if (j < mq.size()) begin
          n_checks++;
          if (bus.data_out[DWID*j +: DWID] !== mq[j]) begin
            n_fail++; $display("FAIL rnd_slot%0d c%0d: got %h want %h", j, c, bus.data_out[DWID*j +: DWID], mq[j]);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus.push = 1'b0; bus.data_in_valid = '0; bus.data_in = '0; bus.pop_valid = '0; bus.flush = 1'b0;
    test_reset();
    test_basic_push();
    test_sparse();
    test_full();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_rst_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
